// File: rtl/spi_pack_pkg.sv
// Shared constants and FSM state encoding for the SPI frame packer.
package spi_pack_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_PACK_N  = 15;
  localparam int DEF_PARTIAL = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and a sticky overflow flag.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic              w_push;
  logic              w_pop;

  // A full FIFO refuses writes even if a pop frees a slot in the same cycle.
  assign w_push     = i_wr_en & ~o_full;
  assign w_pop      = i_rd_en & ~o_empty;
  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_rdata    = r_mem[r_rd_ptr];
  assign o_overflow = r_ovf;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally (power-of-two depth), count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_wr_en && o_full) r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_pack_fifo.sv
// Packs PACK_N FIFO words into one wide frame on a read_req rising edge,
// holding spi_cs low while the frame is assembled.
module spi_pack_fifo
  import spi_pack_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PACK_N  = DEF_PACK_N,
  parameter int PARTIAL = DEF_PARTIAL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       read_req,
  output logic [PACK_N*DATA_W-1:0]   data_out,
  output logic                       data_valid,
  output logic                       spi_cs,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(PACK_N):0]    frame_len,
  output logic                       overflow
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int IDX_W   = $clog2(PACK_N) + 1;
  localparam int FRAME_W = PACK_N * DATA_W;
  localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK_N);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_N - 1);

  state_t              r_state;
  logic                r_req_d;
  logic [IDX_W-1:0]    r_idx;
  logic [FRAME_W-1:0]  r_shift;
  logic [FRAME_W-1:0]  r_data_out;
  logic                r_data_valid;
  logic                r_spi_cs;
  logic [IDX_W-1:0]    r_frame_len;

  logic                w_rise;
  logic                w_ready;
  logic                w_pop;
  logic                w_last;
  logic [DATA_W-1:0]   w_rdata;
  logic [FRAME_W-1:0]  w_frame;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wr_en),
    .i_wdata    (wdata),
    .i_rd_en    (w_pop),
    .o_rdata    (w_rdata),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign spi_cs     = r_spi_cs;
  assign frame_len  = r_frame_len;

  assign w_rise  = read_req & ~r_req_d;
  assign w_ready = (count >= PACK_CNT) || ((PARTIAL != 0) && !empty);
  assign w_pop   = (r_state == ST_COLLECT) && !empty;
  // Partial frames close when this pop drains the FIFO with no refill this cycle.
  assign w_last  = (r_idx == LAST_IDX) ||
                   ((PARTIAL != 0) && (count == ONE_CNT) && !(wr_en && !full));

  // Frame with the word being popped dropped into its slot; slot 0 is the MS slice.
  always_comb begin
    w_frame = r_shift;
    for (int k = 0; k < PACK_N; k++) begin
      if (r_idx == IDX_W'(PACK_N - 1 - k)) w_frame[k*DATA_W +: DATA_W] = w_rdata;
    end
  end

  // Packing FSM with registered frame outputs and read_req edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_d      <= 1'b1;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_spi_cs     <= 1'b1;
      r_frame_len  <= '0;
    end else begin
      r_req_d      <= read_req;
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            if (w_ready) begin
              r_state  <= ST_COLLECT;
              r_spi_cs <= 1'b0;
              r_idx    <= '0;
              r_shift  <= '0;
            end else begin
              r_state  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_ready) begin
            r_state  <= ST_COLLECT;
            r_spi_cs <= 1'b0;
            r_idx    <= '0;
            r_shift  <= '0;
          end
        end
        ST_COLLECT: begin
          if (w_pop) begin
            r_shift <= w_frame;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
              r_state      <= ST_DONE;
              r_data_out   <= w_frame;
              r_data_valid <= 1'b1;
              r_frame_len  <= r_idx + IDX_W'(1);
              r_spi_cs     <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pack_fifo.sv
// Directed bench for spi_pack_fifo: a PARTIAL=0 and a PARTIAL=1 instance,
// expected words tracked in a scoreboard queue.
module tb_spi_pack_fifo;

  localparam int DW = 8, DEPTH = 16, PN = 15, CW = 5, FW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic wr0, wr1, rq0, rq1;
  logic [DW-1:0] wd0, wd1;
  logic [PN*DW-1:0] do0, do1;
  logic dv0, dv1, cs0, cs1, fu0, fu1, em0, em1, ov0, ov1;
  logic [CW-1:0] cn0, cn1;
  logic [FW-1:0] fl0, fl1;

  spi_pack_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PACK_N(PN), .PARTIAL(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr0), .wdata(wd0), .read_req(rq0),
    .data_out(do0), .data_valid(dv0), .spi_cs(cs0), .full(fu0), .empty(em0),
    .count(cn0), .frame_len(fl0), .overflow(ov0));

  spi_pack_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PACK_N(PN), .PARTIAL(1)) dut_p (
    .clk(clk), .rst(rst), .wr_en(wr1), .wdata(wd1), .read_req(rq1),
    .data_out(do1), .data_valid(dv1), .spi_cs(cs1), .full(fu1), .empty(em1),
    .count(cn1), .frame_len(fl1), .overflow(ov1));

  bit sel;
  logic [PN*DW-1:0] dout;
  logic dv, cs, fu, em, ov;
  logic [CW-1:0] cn;
  logic [FW-1:0] fl;

  always_comb begin
    dout = sel ? do1 : do0;
    dv   = sel ? dv1 : dv0;
    cs   = sel ? cs1 : cs0;
    fu   = sel ? fu1 : fu0;
    em   = sel ? em1 : em0;
    ov   = sel ? ov1 : ov0;
    cn   = sel ? cn1 : cn0;
    fl   = sel ? fl1 : fl0;
  end

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input bit en, input logic [DW-1:0] v);
    if (sel) begin wr1 = en; wd1 = v; end
    else     begin wr0 = en; wd0 = v; end
  endtask

  task automatic set_rq(input bit v);
    if (sel) rq1 = v;
    else     rq0 = v;
  endtask

  // One write with no concurrent pop; the model drops it when full.
  task automatic wr(input logic [DW-1:0] v);
    set_wr(1'b1, v);
    tick;
    set_wr(1'b0, '0);
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
  endtask

  // Runs until data_valid (bounded); optionally pulses read_req first and
  // writes a fresh word on every cycle that spi_cs is low.
  task automatic collect(input bit pulse, input bit wr_during, output int cyc, output int nlow);
    logic [DW-1:0] v;
    v = 8'h80;
    cyc = 0;
    nlow = 0;
    if (pulse) set_rq(1'b1);
    while (cyc < 40) begin
      tick;
      set_rq(1'b0);
      set_wr(1'b0, '0);
      cyc++;
      if (dv) break;
      if (!cs) begin
        nlow++;
        if (wr_during) begin
          set_wr(1'b1, v);
          exp_q.push_back(v);
          v++;
        end
      end
    end
  endtask

  // Pop n expected words from the scoreboard; unfilled LS slices must be zero.
  task automatic chk_frame(input string tag, input int n);
    logic [DW-1:0] e;
    for (int k = 0; k < PN; k++) begin
      e = '0;
      if (k < n && exp_q.size() > 0) e = exp_q.pop_front();
      chk($sformatf("%s_w%0d", tag, k), 32'(dout[(PN-1-k)*DW +: DW]), 32'(e));
    end
  endtask

  logic [DW-1:0] t1 [PN];
  int cyc, nlow;
  bit seen;

  initial begin
    t1 = '{8'd1, 8'd2, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70,
           8'd100, 8'd120, 8'd130, 8'd140, 8'd150, 8'd55, 8'd200};
    sel = 1'b0;
    rst = 1'b1;
    wr0 = 1'b0; wr1 = 1'b0; wd0 = '0; wd1 = '0;
    rq0 = 1'b1; rq1 = 1'b1;

    // Reset with read_req held high: no trigger after release.
    repeat (2) tick;
    rst = 1'b0;
    repeat (3) tick;
    chk("rst_cs", 32'(cs0), 32'd1);
    chk("rst_cs_p", 32'(cs1), 32'd1);
    chk("rst_dv", 32'(dv0), 32'd0);
    chk("rst_cnt", 32'(cn0), 32'd0);
    chk("rst_empty", 32'(em0), 32'd1);
    chk("rst_full", 32'(fu0), 32'd0);
    chk("rst_ovf", 32'(ov0), 32'd0);
    chk("rst_flen", 32'(fl0), 32'd0);
    chk("rst_dout", 32'(do0 === '0), 32'd1);
    rq0 = 1'b0; rq1 = 1'b0;
    tick;

    // Full frame from stored data: latency and byte order.
    for (int i = 0; i < PN; i++) wr(t1[i]);
    chk("t1_cnt", 32'(cn), 32'd15);
    collect(1'b1, 1'b0, cyc, nlow);
    chk("t1_lat", 32'(cyc), 32'd16);
    chk("t1_cslow", 32'(nlow), 32'd15);
    chk("t1_cs_done", 32'(cs), 32'd1);
    chk_frame("t1", PN);
    chk("t1_flen", 32'(fl), 32'd15);
    chk("t1_cnt_end", 32'(cn), 32'd0);
    tick;
    chk("t1_dv_once", 32'(dv), 32'd0);

    // Not enough data: WAIT with spi_cs high, then start once 15 are stored.
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    set_rq(1'b1);
    tick;
    set_rq(1'b0);
    repeat (3) tick;
    chk("t2_wait_cs", 32'(cs), 32'd1);
    chk("t2_wait_cnt", 32'(cn), 32'd5);
    for (int i = 0; i < 10; i++) wr(8'h20 + 8'(i));
    chk("t2_cs_pre", 32'(cs), 32'd1);
    collect(1'b0, 1'b0, cyc, nlow);
    chk("t2_lat", 32'(cyc), 32'd16);
    chk("t2_cslow", 32'(nlow), 32'd15);
    chk_frame("t2", PN);
    chk("t2_flen", 32'(fl), 32'd15);
    tick;

    // Writes every COLLECT cycle from count=15: count holds, order kept.
    for (int i = 0; i < PN; i++) wr(8'h40 + 8'(i));
    collect(1'b1, 1'b1, cyc, nlow);
    chk("t3_lat", 32'(cyc), 32'd16);
    chk_frame("t3", PN);
    chk("t3_cnt", 32'(cn), 32'd15);
    chk("t3_ovf", 32'(ov), 32'd0);
    tick;
    collect(1'b1, 1'b0, cyc, nlow);
    chk("t3b_lat", 32'(cyc), 32'd16);
    chk_frame("t3b", PN);
    chk("t3b_cnt", 32'(cn), 32'd0);
    tick;

    // Overflow: 17 writes, sticky flag survives a frame.
    for (int i = 0; i < 17; i++) begin
      wr(8'h60 + 8'(i));
      if (i == 15) chk("t4_full16", 32'(fu), 32'd1);
    end
    chk("t4_ovf", 32'(ov), 32'd1);
    chk("t4_cnt", 32'(cn), 32'd16);
    collect(1'b1, 1'b0, cyc, nlow);
    chk("t4_lat", 32'(cyc), 32'd16);
    chk_frame("t4", PN);
    chk("t4_cnt_end", 32'(cn), 32'd1);
    chk("t4_ovf_end", 32'(ov), 32'd1);
    tick;

    // Reset in the 5th COLLECT cycle drops everything, no frame appears.
    for (int i = 0; i < 14; i++) wr(8'hC0 + 8'(i));
    chk("t5_cnt", 32'(cn), 32'd15);
    set_rq(1'b1);
    tick;
    set_rq(1'b0);
    repeat (4) tick;
    chk("t5_in_collect", 32'(cs), 32'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_cs", 32'(cs), 32'd1);
    chk("t5_cnt0", 32'(cn), 32'd0);
    chk("t5_dv", 32'(dv), 32'd0);
    chk("t5_dout", 32'(dout === '0), 32'd1);
    chk("t5_ovf", 32'(ov), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (dv) seen = 1'b1;
    end
    chk("t5_no_dv", 32'(seen), 32'd0);
    exp_q.delete();

    // PARTIAL=1: three words pack with zero padding.
    sel = 1'b1;
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    collect(1'b1, 1'b0, cyc, nlow);
    chk("t6_lat", 32'(cyc), 32'd4);
    chk("t6_cslow", 32'(nlow), 32'd3);
    chk_frame("t6", 3);
    chk("t6_flen", 32'(fl), 32'd3);
    chk("t6_cnt", 32'(cn), 32'd0);
    tick;

    // PARTIAL=1 request on empty FIFO waits, then packs a single word.
    set_rq(1'b1);
    tick;
    set_rq(1'b0);
    repeat (2) tick;
    chk("t7_wait_cs", 32'(cs), 32'd1);
    wr(8'h5C);
    collect(1'b0, 1'b0, cyc, nlow);
    chk("t7_lat", 32'(cyc), 32'd2);
    chk("t7_cslow", 32'(nlow), 32'd1);
    chk_frame("t7", 1);
    chk("t7_flen", 32'(fl), 32'd1);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_pack_fifo.md
SPI_PACK_FIFO -- requirements
Module: spi_pack_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one written byte/word.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, DEPTH >= PACK_N.
REQ-003 SHALL have parameter PACK_N, default 15, words packed per output frame.
REQ-004 SHALL have parameter PARTIAL, default 0; 1 = a request with fewer than PACK_N stored packs what is present and zero-pads.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have ports wr_en (input, 1, write strobe) and wdata (input, DATA_W, write data).
REQ-008 SHALL have port read_req, input, 1, level; the block acts on its rising edge only.
REQ-009 SHALL have ports data_out (output, PACK_N*DATA_W, packed frame) and data_valid (output, 1, one-cycle frame strobe).
REQ-010 SHALL have port spi_cs, output, 1, active-low chip select, low while a frame is being assembled.
REQ-011 SHALL have ports full, empty (output, 1), count (output, $clog2(DEPTH)+1, stored entries) and frame_len (output, $clog2(PACK_N)+1, valid words in last frame).
REQ-012 SHALL have port overflow, output, 1, sticky write-while-full flag.

Function
REQ-013 Write: wr_en=1 and not full stores wdata at the write pointer; wr_en=1 while full drops the word and sets overflow.
REQ-014 Pointers wrap from DEPTH-1 to 0; full = (count==DEPTH), empty = (count==0), both combinational from count.
REQ-015 A write and an internal pop in the same cycle leave count unchanged; a write while full is not accepted even when a pop occurs that cycle.
REQ-016 FSM states: IDLE, WAIT, COLLECT, DONE.
REQ-017 IDLE: on a read_req rising edge, go to COLLECT when count >= PACK_N (or PARTIAL=1 and count>0); otherwise go to WAIT.
REQ-018 WAIT (PARTIAL=0 or empty): go to COLLECT in the first cycle where the IDLE condition holds; spi_cs stays high.
REQ-019 COLLECT: spi_cs=0; pop one word per cycle into the frame shift register, first popped word in the MS slice [PACK_N*DATA_W-1 -: DATA_W].
REQ-020 COLLECT ends after PACK_N pops, or in PARTIAL mode when the FIFO empties; in the latter case remaining LS slices are zero.
REQ-021 DONE (one cycle): data_out updates, data_valid=1, frame_len = words popped, spi_cs=1; next state IDLE.
REQ-022 Latency: edge sampled in cycle 0 with data available gives spi_cs low cycles 1..PACK_N and data_valid in cycle PACK_N+1.
REQ-023 read_req edges in WAIT, COLLECT or DONE are ignored (no queuing).
REQ-024 data_out holds the last frame until the next DONE; writes continue during COLLECT.
REQ-025 overflow clears only on rst.

Reset
REQ-026 rst=1 at a clock edge: pointers and count=0, state IDLE, data_out=0, data_valid=0, spi_cs=1, frame_len=0, overflow=0, edge detector primed so read_req held high does not trigger after release.
REQ-027 rst mid-COLLECT discards the partial frame and all stored data; no data_valid is produced.

Structure
REQ-028 Package spi_pack_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-029 Storage and pointers SHALL be a sub-module sync_fifo (DATA_W, DEPTH); packing FSM, shift register and edge detect in the top.

Verification (DATA_W=8, DEPTH=16, PACK_N=15)
REQ-030 Write 1,2,20,30,40,50,60,70,100,120,130,140,150,55,200, pulse read_req -> spi_cs low 15 cycles, data_valid once, data_out MS byte 1, LS byte 200, frame_len=15, count=0.
REQ-031 Write 5 words, pulse read_req (PARTIAL=0) -> WAIT, spi_cs high; write 10 more -> frame starts the next cycle, data_valid 16 cycles later.
REQ-032 PARTIAL=1, write 3 words 0xA1,0xA2,0xA3, pulse read_req -> data_valid after 3 pops, top 3 bytes A1 A2 A3, rest 0, frame_len=3.
REQ-033 Write 17 words with no read -> full after 16, overflow=1, count=16; pop a frame -> overflow stays 1, count=1.
REQ-034 Assert rst in the 5th COLLECT cycle -> spi_cs=1, count=0, no data_valid, data_out=0 next cycle.
REQ-035 Write every cycle during COLLECT from count=15 -> count ends at 15 after DONE, the popped order is preserved, no overflow.
